// File: rtl/spi_mailbox.sv
// spi_mailbox: byte mailbox between the SPI wrapper echo path and the core bus.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_buff, rx_valid     : bytes from the wrapper into the RX FIFO
//   tx_buff, tx_valid     : head of the TX FIFO toward the wrapper
//   tx_ack                : wrapper took tx_buff; pops the TX FIFO
//   bus_addr/we/re/wdata  : word-addressed register bus (DATA, STATUS, CTRL, reserved)
//   bus_rdata             : registered read data, held until the next read
//   irq                   : registered level interrupt
module spi_mailbox #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_buff,
  input  logic        rx_valid,
  output logic [7:0]  tx_buff,
  output logic        tx_valid,
  input  logic        tx_ack,
  input  logic [1:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_CTRL   = 2'd2,
    ADDR_RSVD   = 2'd3
  } addr_e;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    rx_mem_d [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    tx_mem_d [DEPTH];
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
  logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic          rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic data_sel, ctrl_wr;
  logic rx_pop, rx_push, rx_ovf_set, rx_flush;
  logic tx_pop, tx_push, tx_ovf_set, tx_flush;
  logic [31:0] status_word;
  logic unused_wdata;

  assign unused_wdata = ^bus_wdata[31:6];

  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == CW'(DEPTH));
  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == CW'(DEPTH));

  assign data_sel = (bus_addr == ADDR_DATA);
  assign ctrl_wr  = bus_we && (bus_addr == ADDR_CTRL);
  assign rx_flush = ctrl_wr && bus_wdata[4];
  assign tx_flush = ctrl_wr && bus_wdata[5];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted then. A flush discards the byte without flagging overflow.
  assign rx_pop     = bus_re && data_sel && !rx_empty;
  assign rx_push    = rx_valid && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_valid && rx_full && !rx_pop && !rx_flush;

  assign tx_pop     = tx_ack && !tx_empty;
  assign tx_push    = bus_we && data_sel && (!tx_full || tx_pop);
  assign tx_ovf_set = bus_we && data_sel && tx_full && !tx_pop && !tx_flush;

  assign tx_valid = !tx_empty;
  assign tx_buff  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];

  always_comb begin
    status_word = '0;
    status_word[CW-1:0]    = rx_count_q;
    status_word[2*CW-1:CW] = tx_count_q;
    status_word[2*CW +: 6] = {tx_ovf_q, rx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};
  end

  always_comb begin
    rx_mem_d   = rx_mem_q;
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;
    rx_count_d = rx_count_q;
    if (rx_flush) begin
      rx_wr_d    = '0;
      rx_rd_d    = '0;
      rx_count_d = '0;
    end else begin
      if (rx_push) begin
        rx_mem_d[rx_wr_q] = rx_buff;
        rx_wr_d           = rx_wr_q + AW'(1);
      end
      if (rx_pop) begin
        rx_rd_d = rx_rd_q + AW'(1);
      end
      rx_count_d = rx_count_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_wr_d    = tx_wr_q;
    tx_rd_d    = tx_rd_q;
    tx_count_d = tx_count_q;
    if (tx_flush) begin
      tx_wr_d    = '0;
      tx_rd_d    = '0;
      tx_count_d = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wr_q] = bus_wdata[7:0];
        tx_wr_d           = tx_wr_q + AW'(1);
      end
      if (tx_pop) begin
        tx_rd_d = tx_rd_q + AW'(1);
      end
      tx_count_d = tx_count_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_comb begin
    rx_ovf_d    = (ctrl_wr && bus_wdata[2]) ? 1'b0 : (rx_ovf_q || rx_ovf_set);
    tx_ovf_d    = (ctrl_wr && bus_wdata[3]) ? 1'b0 : (tx_ovf_q || tx_ovf_set);
    rx_irq_en_d = ctrl_wr ? bus_wdata[0] : rx_irq_en_q;
    tx_irq_en_d = ctrl_wr ? bus_wdata[1] : tx_irq_en_q;
    irq_d = (rx_irq_en_q && !rx_empty) || (tx_irq_en_q && tx_empty) || rx_ovf_q || tx_ovf_q;

    rdata_d = rdata_q;
    if (bus_re) begin
      case (addr_e'(bus_addr))
        ADDR_DATA:   rdata_d = rx_empty ? 32'h0000_0100 : {24'h0, rx_mem_q[rx_rd_q]};
        ADDR_STATUS: rdata_d = status_word;
        ADDR_CTRL:   rdata_d = {30'h0, tx_irq_en_q, rx_irq_en_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  // Storage arrays carry no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    rx_mem_q <= rx_mem_d;
    tx_mem_q <= tx_mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_count_q  <= '0;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      tx_count_q  <= '0;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      rx_count_q  <= rx_count_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      tx_count_q  <= tx_count_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_irq_en_q <= rx_irq_en_d;
      tx_irq_en_q <= tx_irq_en_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_spi_mailbox.sv
// tb_spi_mailbox: directed and random stimulus for spi_mailbox, checked
// against a queue-based reference model through an expectation scoreboard.
module tb_spi_mailbox;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_buff = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_buff;
  logic        tx_valid;
  logic        tx_ack = 1'b0;
  logic [1:0]  bus_addr = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        irq;

  spi_mailbox #(.DEPTH(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_buff(rx_buff), .rx_valid(rx_valid),
    .tx_buff(tx_buff), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        txv;
    logic [7:0]  txb;
    logic        irq;
  } exp_t;

  exp_t expq[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  bit          m_rxovf, m_txovf, m_rxen, m_txen, m_irq;
  logic [31:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rx.delete(); m_tx.delete();
    m_rxovf = 0; m_txovf = 0; m_rxen = 0; m_txen = 0; m_irq = 0;
    m_rdata = '0;
  endtask

  task automatic model_step(input bit rxv, input logic [7:0] rxb, input bit ack,
                            input logic [1:0] addr, input bit we, input bit re,
                            input logic [31:0] wd);
    int rn = m_rx.size();
    int tn = m_tx.size();
    bit ctrl_wr = we && (addr == 2'd2);
    bit rset = 0, tset = 0;
    bit irq_next;
    logic [31:0] st;
    st = rn | (tn << 4) | (int'(rn == 0) << 8) | (int'(rn == DEPTH) << 9)
       | (int'(tn == 0) << 10) | (int'(tn == DEPTH) << 11)
       | (int'(m_rxovf) << 12) | (int'(m_txovf) << 13);
    irq_next = (m_rxen && rn != 0) || (m_txen && tn == 0) || m_rxovf || m_txovf;
    if (re) begin
      case (addr)
        2'd0: m_rdata = (rn == 0) ? 32'h100 : {24'h0, m_rx[0]};
        2'd1: m_rdata = st;
        2'd2: m_rdata = {30'h0, m_txen, m_rxen};
        default: m_rdata = 32'h0;
      endcase
    end
    // RX: read frees a slot before the incoming byte is considered
    if (ctrl_wr && wd[4]) m_rx.delete();
    else begin
      if (re && addr == 2'd0 && rn > 0) m_rx.delete(0);
      if (rxv) begin
        if (m_rx.size() < DEPTH) m_rx.push_back(rxb);
        else rset = 1;
      end
    end
    if (ctrl_wr && wd[5]) m_tx.delete();
    else begin
      if (ack && tn > 0) m_tx.delete(0);
      if (we && addr == 2'd0) begin
        if (m_tx.size() < DEPTH) m_tx.push_back(wd[7:0]);
        else tset = 1;
      end
    end
    if (ctrl_wr && wd[2]) m_rxovf = 0; else if (rset) m_rxovf = 1;
    if (ctrl_wr && wd[3]) m_txovf = 0; else if (tset) m_txovf = 1;
    if (ctrl_wr) begin m_rxen = wd[0]; m_txen = wd[1]; end
    m_irq = irq_next;
  endtask

  task automatic cyc(input bit rxv, input logic [7:0] rxb, input bit ack,
                     input logic [1:0] addr, input bit we, input bit re,
                     input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    rx_valid = rxv; rx_buff = rxb; tx_ack = ack;
    bus_addr = addr; bus_we = we; bus_re = re; bus_wdata = wd;
    model_step(rxv, rxb, ack, addr, we, re, wd);
    e.rdata = m_rdata;
    e.txv   = (m_tx.size() != 0);
    e.txb   = (m_tx.size() != 0) ? m_tx[0] : 8'h00;
    e.irq   = m_irq;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 2'd0, 0, 0, 32'h0);
  endtask
  task automatic rxpush(input logic [7:0] b); cyc(1, b, 0, 2'd0, 0, 0, 32'h0); endtask
  task automatic rd(input logic [1:0] a);     cyc(0, 8'h00, 0, a, 0, 1, 32'h0); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); cyc(0, 8'h00, 0, a, 1, 0, d); endtask
  task automatic ack1();                      cyc(0, 8'h00, 1, 2'd0, 0, 0, 32'h0); endtask

  // Monitor: each item pushed before an edge is compared just after that edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("bus_rdata", bus_rdata, e.rdata);
      check("tx_valid", 32'(tx_valid), 32'(e.txv));
      check("tx_buff", 32'(tx_buff), 32'(e.txb));
      check("irq", 32'(irq), 32'(e.irq));
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rdata", bus_rdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    check("reset_tx_buff", 32'(tx_buff), 32'h0);
    rst_n = 1'b1;

    rd(2'd1); idle(1);

    rxpush(8'hAA); rxpush(8'hBB); rxpush(8'hCC);
    repeat (4) rd(2'd0);
    rd(2'd1); idle(1);

    for (int i = 1; i <= 9; i++) rxpush(8'(i));
    rd(2'd1); idle(2);
    repeat (8) rd(2'd0);
    wr(2'd2, 32'h4); idle(2); rd(2'd1); idle(1);

    wr(2'd0, 32'hCA); wr(2'd0, 32'hFE); idle(1);
    ack1(); ack1(); ack1(); rd(2'd1); idle(1);

    for (int i = 0; i < 8; i++) rxpush(8'h10 + 8'(i));
    for (int i = 0; i < 12; i++) cyc(1, 8'h40 + 8'(i), 0, 2'd0, 0, 1, 32'h0);
    rd(2'd1);
    repeat (9) rd(2'd0);

    wr(2'd2, 32'h1); rxpush(8'h5A);
    wr(2'd0, 32'h11); wr(2'd0, 32'h22); wr(2'd0, 32'h33); idle(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_tx_valid", 32'(tx_valid), 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    check("async_tx_buff", 32'(tx_buff), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(2'd1); idle(1);

    for (int n = 0; n < 1500; n++) begin
      bit rxv, ack, we, re;
      logic [1:0] a;
      logic [31:0] wd;
      rxv = ($urandom_range(0, 99) < 40);
      ack = ($urandom_range(0, 99) < 30);
      we  = ($urandom_range(0, 99) < 30);
      re  = ($urandom_range(0, 99) < 35);
      a   = ($urandom_range(0, 99) < 55) ? 2'd0 : 2'($urandom_range(1, 3));
      wd  = $urandom;
      if (a == 2'd2 && $urandom_range(0, 7) != 0) wd[5:4] = 2'b00;
      cyc(rxv, 8'($urandom), ack, a, we, re, wd);
    end
    idle(2);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
